hs_ram_arbiter: RTL

- Shares the game core's single-port work RAM between the main CPU and the hiscore save/restore engine.
- On a hiscore access request, it asks the pause system to halt the CPU and waits for the CPU to be confirmed paused. It then lets the RAM port settle, grants the port to the hiscore engine, and hands it back cleanly.
- Sits between the hiscore block, the pause block and the game core's work-RAM port, all in the clk_sys domain.

---
 rtl/hs_ram_arb_pkg.sv | 18 +
 rtl/hs_arb_timer.sv | 27 ++
 rtl/hs_ram_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/hs_ram_arb_pkg.sv
// Shared types and constants for the hiscore/CPU work-RAM arbiter.
package hs_ram_arb_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PAUSE_WAIT = 3'd1,
      SETTLE     = 3'd2,
      GRANT      = 3'd3,
      RELEASE    = 3'd4
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_HS  = 1'b1;

endpackage

// File: rtl/hs_arb_timer.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module hs_arb_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hs_ram_arbiter.sv
// Hands the game core's single-port work RAM to the hiscore engine while the CPU is paused.
// Optional pause timeout: define HS_RAM_ARB_TIMEOUT_EN.
module hs_ram_arbiter
   import hs_ram_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int SETTLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              hs_req,
   input  logic [ADDR_W-1:0] hs_addr,
   input  logic [DATA_W-1:0] hs_wdata,
   input  logic              hs_we,
   output logic [DATA_W-1:0] hs_rdata,
   output logic              hs_grant,
   output logic              pause_req,
   input  logic              cpu_paused,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [7:0]        blocked_wr,
   output logic              abort_flag
);

   if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("hs_ram_arbiter: SETTLE_CYC must be 1..15");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("hs_ram_arbiter: TIMEOUT_CYC must be 1..65535");
   end

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   arb_state_t state;
   logic       own_sel;
   logic       armed;
   logic       settle_zero;
   logic       timeout_hit;

   hs_arb_timer #(.W(4)) u_settle_timer (
      .clk      (clk_sys),
      .rst_n    (reset_n),
      .load     ((state == PAUSE_WAIT) && hs_req && cpu_paused),
      .load_val (SETTLE_LOAD),
      .dec      (state == SETTLE),
      .zero     (settle_zero)
   );

`ifdef HS_RAM_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LOAD = 16'(TIMEOUT_CYC - 1);
   logic timeout_zero;

   hs_arb_timer #(.W(16)) u_timeout_timer (
      .clk      (clk_sys),
      .rst_n    (reset_n),
      .load     ((state == IDLE) && hs_req),
      .load_val (TIMEOUT_LOAD),
      .dec      (state == PAUSE_WAIT),
      .zero     (timeout_zero)
   );

   assign timeout_hit = (state == PAUSE_WAIT) && timeout_zero;
`else
   assign timeout_hit = 1'b0;
`endif

   // Losing the pause during a grant outranks a normal hs_req drop.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         pause_req  <= 1'b0;
         hs_grant   <= 1'b0;
         own_sel    <= OWN_CPU;
         abort_flag <= 1'b0;
         blocked_wr <= 8'd0;
         armed      <= 1'b0;
      end else begin
         armed <= 1'b1;
         if (cpu_we && (state != IDLE) && (blocked_wr != 8'hFF)) begin
            blocked_wr <= blocked_wr + 8'd1;
         end
         case (state)
            IDLE: begin
               if (hs_req) begin
                  state     <= PAUSE_WAIT;
                  pause_req <= 1'b1;
               end
            end
            PAUSE_WAIT: begin
               if (!hs_req) begin
                  state <= RELEASE;
               end else if (cpu_paused) begin
                  state   <= SETTLE;
                  own_sel <= OWN_HS;
               end else if (timeout_hit) begin
                  abort_flag <= 1'b1;
                  state      <= RELEASE;
               end
            end
            SETTLE: begin
               if (!hs_req) begin
                  state <= RELEASE;
               end else if (settle_zero) begin
                  state    <= GRANT;
                  hs_grant <= 1'b1;
               end
            end
            GRANT: begin
               if (!cpu_paused) begin
                  abort_flag <= 1'b1;
                  hs_grant   <= 1'b0;
                  state      <= RELEASE;
               end else if (!hs_req) begin
                  hs_grant <= 1'b0;
                  state    <= RELEASE;
               end
            end
            RELEASE: begin
               state     <= IDLE;
               pause_req <= 1'b0;
               own_sel   <= OWN_CPU;
            end
            default: begin
               state     <= IDLE;
               pause_req <= 1'b0;
               hs_grant  <= 1'b0;
               own_sel   <= OWN_CPU;
            end
         endcase
      end
   end

   assign ram_addr  = (own_sel == OWN_HS) ? hs_addr  : cpu_addr;
   assign ram_wdata = (own_sel == OWN_HS) ? hs_wdata : cpu_wdata;

   // CPU writes pass only from IDLE, and never in the first cycle out of reset.
   always_comb begin
      ram_we = 1'b0;
      if (hs_grant) begin
         ram_we = hs_we;
      end else if ((state == IDLE) && armed) begin
         ram_we = cpu_we;
      end
   end

   assign cpu_rdata = ram_rdata;
   assign hs_rdata  = ram_rdata;

endmodule
